retire_map: RTL and testbench

Commit-side consumer of the ROB retirement interface. Holds the committed (architectural) register map and recycles physical tags for rename. Each committing lane updates the committed map and returns the superseded tag to a circular free list. The free list supplies tags to rename allocation, and a pipeline flush rewinds its speculative head to the committed head.

---
 rtl/core_pkg.sv | 17 +
 rtl/retire_map_if.sv | 22 ++
 rtl/preg_freelist.sv | 40 ++++
 rtl/retire_map.sv | 53 +++++
 tb/tb_retire_map.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared rename/commit sizes, physical tag and free-list pointer types, lane popcount helper
package core_pkg;
  localparam int ISSUE_WIDTH = 2;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int XZR_IDX = 31;
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int FL_PW = $clog2(FL_DEPTH) + 1;
  typedef logic [TAG_W-1:0] preg_tag_t;
  typedef logic [FL_PW-1:0] fl_ptr_t;
  typedef logic [4:0] areg_t;
  function automatic fl_ptr_t popcnt(input logic [ISSUE_WIDTH-1:0] v, input int n);
    popcnt = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) if (i < n) popcnt = popcnt + fl_ptr_t'(v[i]);
  endfunction
endpackage

// File: rtl/retire_map_if.sv
// retire_map_if: rename alloc + ROB commit bundle; master = rename/ROB side, slave = retire_map (alloc_req/tag/ok, commit_*, flush_en, exc_flush, free_count)
interface retire_map_if;
  import core_pkg::*;
  logic [ISSUE_WIDTH-1:0] alloc_req;
  preg_tag_t [ISSUE_WIDTH-1:0] alloc_tag;
  logic alloc_ok;
  logic [ISSUE_WIDTH-1:0] commit_valid;
  areg_t [ISSUE_WIDTH-1:0] commit_arch_rd;
  preg_tag_t [ISSUE_WIDTH-1:0] commit_phys_rd;
  logic [ISSUE_WIDTH-1:0] commit_exception;
  logic flush_en;
  logic exc_flush;
  fl_ptr_t free_count;
  modport master (
    output alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, commit_exception, flush_en,
    input alloc_tag, alloc_ok, exc_flush, free_count
  );
  modport slave (
    input alloc_req, commit_valid, commit_arch_rd, commit_phys_rd, commit_exception, flush_en,
    output alloc_tag, alloc_ok, exc_flush, free_count
  );
endinterface

// File: rtl/preg_freelist.sv
// preg_freelist: circular physical-tag free list; pop_req/pop_tag/pop_ok allocate from head_spec, push_valid/push_tag append at tail and advance head_commit, flush rewinds head_spec, free_count = tail - head_spec
module preg_freelist
  import core_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ISSUE_WIDTH-1:0]      pop_req,
  output preg_tag_t [ISSUE_WIDTH-1:0] pop_tag,
  output logic                        pop_ok,
  input  logic                        flush,
  input  logic [ISSUE_WIDTH-1:0]      push_valid,
  input  preg_tag_t [ISSUE_WIDTH-1:0] push_tag,
  output fl_ptr_t                     free_count
);
  localparam int IDX_W = $clog2(FL_DEPTH);
  preg_tag_t mem [FL_DEPTH];
  fl_ptr_t head_spec, head_commit, tail, n_pop, n_push;
  always_comb begin
    n_pop = popcnt(pop_req, ISSUE_WIDTH);
    n_push = popcnt(push_valid, ISSUE_WIDTH);
    free_count = tail - head_spec;
    pop_ok = free_count >= n_pop && !flush;
    for (int i = 0; i < ISSUE_WIDTH; i++) pop_tag[i] = mem[IDX_W'(head_spec + popcnt(pop_req, i))];
  end
  // every retiring tag consumed one committed entry, so head_commit and tail move together
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= preg_tag_t'(ARCH_REGS + i);
      head_spec <= '0;
      head_commit <= '0;
      tail <= fl_ptr_t'(FL_DEPTH);
    end else begin
      for (int i = 0; i < ISSUE_WIDTH; i++)
        if (push_valid[i]) mem[IDX_W'(tail + popcnt(push_valid, i))] <= push_tag[i];
      tail <= tail + n_push;
      head_commit <= head_commit + n_push;
      head_spec <= flush ? head_commit + n_push : head_spec + (pop_ok ? n_pop : '0);
    end
  end
endmodule

// File: rtl/retire_map.sv
// retire_map: committed arch->phys map with in-order lane gating, stale-tag forwarding and registered exc_flush; ports clk, reset, bus (retire_map_if.slave); LEGV8_XZR_EN makes arch reg 31 a map-less zero register
module retire_map
  import core_pkg::*;
(
  input logic         clk,
  input logic         reset,
  retire_map_if.slave bus
);
  preg_tag_t map [ARCH_REGS];
  logic [ISSUE_WIDTH-1:0] ret, dst;
  preg_tag_t [ISSUE_WIDTH-1:0] stale;
  logic exc_any, exc_q;
  always_comb begin
    exc_any = 1'b0;
    ret = '0;
    dst = '0;
    stale = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      ret[i] = bus.commit_valid[i] && !bus.commit_exception[i] && !exc_any;
      exc_any = exc_any | (bus.commit_valid[i] && bus.commit_exception[i]);
`ifdef LEGV8_XZR_EN
      dst[i] = ret[i] && bus.commit_arch_rd[i] != areg_t'(XZR_IDX);
`else
      dst[i] = ret[i];
`endif
      stale[i] = map[bus.commit_arch_rd[i]];
      // youngest older lane writing the same register supplies the superseded tag
      for (int j = 0; j < i; j++)
        if (dst[j] && bus.commit_arch_rd[j] == bus.commit_arch_rd[i]) stale[i] = bus.commit_phys_rd[j];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map[i] <= preg_tag_t'(i);
      exc_q <= 1'b0;
    end else begin
      for (int i = 0; i < ISSUE_WIDTH; i++) if (dst[i]) map[bus.commit_arch_rd[i]] <= bus.commit_phys_rd[i];
      exc_q <= exc_any;
    end
  end
  assign bus.exc_flush = exc_q;
  preg_freelist u_fl (
    .clk(clk),
    .reset(reset),
    .pop_req(bus.alloc_req),
    .pop_tag(bus.alloc_tag),
    .pop_ok(bus.alloc_ok),
    .flush(bus.flush_en),
    .push_valid(dst),
    .push_tag(stale),
    .free_count(bus.free_count)
  );
endmodule

// File: tb/tb_retire_map.sv
// tb_retire_map: directed + random stimulus against a queue-based free-list/map model
module tb_retire_map;
  import core_pkg::*;
`ifdef LEGV8_XZR_EN
  localparam bit XZR = 1'b1;
`else
  localparam bit XZR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  retire_map_if bus();
  retire_map dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0, errors = 0;
  int fl[$];
  int inflight[$];
  int s;
  int mp[ARCH_REGS];
  bit exc_q;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit is_dst(int rd);
    return !(XZR && rd == XZR_IDX);
  endfunction
  task automatic model_reset();
    fl.delete();
    inflight.delete();
    for (int i = ARCH_REGS; i < PHYS_REGS; i++) fl.push_back(i);
    for (int i = 0; i < ARCH_REGS; i++) mp[i] = i;
    s = 0;
    exc_q = 1'b0;
  endtask
  always @(negedge clk) begin
    int n, pre, avail, k;
    bit ok, ex;
    int freed[$];
    int got[$];
    if (reset) model_reset();
    else begin
      freed.delete();
      got.delete();
      n = 0;
      for (int i = 0; i < ISSUE_WIDTH; i++) n += int'(bus.alloc_req[i]);
      avail = fl.size() - s;
      ok = avail >= n && !bus.flush_en;
      chk("free_count", int'(bus.free_count), avail);
      chk("alloc_ok", int'(bus.alloc_ok), int'(ok));
      chk("exc_flush", int'(bus.exc_flush), int'(exc_q));
      pre = 0;
      for (int i = 0; i < ISSUE_WIDTH; i++)
        if (bus.alloc_req[i]) begin
          if (ok) begin
            chk($sformatf("alloc_tag%0d", i), int'(bus.alloc_tag[i]), fl[s + pre]);
            got.push_back(fl[s + pre]);
          end
          pre++;
        end
      ex = 1'b0;
      k = 0;
      for (int i = 0; i < ISSUE_WIDTH; i++)
        if (bus.commit_valid[i] && !ex) begin
          if (bus.commit_exception[i]) ex = 1'b1;
          else if (is_dst(int'(bus.commit_arch_rd[i]))) begin
            freed.push_back(mp[bus.commit_arch_rd[i]]);
            mp[bus.commit_arch_rd[i]] = int'(bus.commit_phys_rd[i]);
            k++;
          end
        end
      exc_q = ex;
      repeat (k) begin
        void'(fl.pop_front());
        if (inflight.size() > 0) void'(inflight.pop_front());
      end
      foreach (freed[j]) fl.push_back(freed[j]);
      if (bus.flush_en) begin
        s = 0;
        inflight.delete();
      end else s = s - k + (ok ? n : 0);
      foreach (got[j]) inflight.push_back(got[j]);
    end
  end
  task automatic drive(logic [1:0] areq, logic [1:0] cv, int rd0, int pd0, int rd1, int pd1,
                       logic [1:0] ce, logic fe);
    @(posedge clk);
    #1;
    bus.alloc_req = areq;
    bus.commit_valid = cv;
    bus.commit_arch_rd[0] = areg_t'(rd0);
    bus.commit_phys_rd[0] = preg_tag_t'(pd0);
    bus.commit_arch_rd[1] = areg_t'(rd1);
    bus.commit_phys_rd[1] = preg_tag_t'(pd1);
    bus.commit_exception = ce;
    bus.flush_en = fe;
    #1;
  endtask
  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask
  initial begin
    logic [1:0] v, e, areq;
    int rd[2], pd[2];
    int used;
    bit ex;
    bus.alloc_req = '0;
    bus.commit_valid = '0;
    bus.commit_arch_rd = '0;
    bus.commit_phys_rd = '0;
    bus.commit_exception = '0;
    bus.flush_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset free_count", int'(bus.free_count), 32);
    chk("reset exc_flush", int'(bus.exc_flush), 0);
    drive(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    chk("first tag0", int'(bus.alloc_tag[0]), 32);
    chk("first tag1", int'(bus.alloc_tag[1]), 33);
    chk("first ok", int'(bus.alloc_ok), 1);
    drive(2'b00, 2'b11, 1, 32, 2, 33, 2'b00, 1'b0);
    chk("after alloc free", int'(bus.free_count), 30);
    idle();
    chk("after commit free", int'(bus.free_count), 32);
    drive(2'b00, 2'b11, 7, 50, 8, 51, 2'b01, 1'b0);
    chk("exc same cycle", int'(bus.exc_flush), 0);
    idle();
    chk("exc pulse", int'(bus.exc_flush), 1);
    chk("exc no free", int'(bus.free_count), 32);
    idle();
    chk("exc one cycle", int'(bus.exc_flush), 0);
    drive(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    chk("alloc34", int'(bus.alloc_tag[0]), 34);
    repeat (3) drive(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    drive(2'b00, 2'b11, 6, 34, 7, 35, 2'b00, 1'b0);
    drive(2'b00, 2'b11, 8, 36, 9, 37, 2'b00, 1'b0);
    drive(2'b00, 2'b11, 10, 38, 11, 39, 2'b00, 1'b0);
    drive(2'b00, 2'b11, 5, 40, 5, 41, 2'b00, 1'b0);
    idle();
    chk("same rd free", int'(bus.free_count), 32);
    repeat (2) drive(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    drive(2'b11, 2'b01, 12, 42, 0, 0, 2'b00, 1'b1);
    chk("flush alloc_ok", int'(bus.alloc_ok), 0);
    idle();
    chk("flush free", int'(bus.free_count), 32);
    for (int c = 0; c < 16; c++) begin
      drive(2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
      if (c == 0) chk("drain tag0", int'(bus.alloc_tag[0]), 43);
      if (c == 14) chk("drain stale5", int'(bus.alloc_tag[1]), 5);
      if (c == 15) begin
        chk("drain fwd40", int'(bus.alloc_tag[0]), 40);
        chk("drain tag12", int'(bus.alloc_tag[1]), 12);
      end
    end
    drive(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    chk("empty free", int'(bus.free_count), 0);
    chk("empty ok", int'(bus.alloc_ok), 0);
    drive(2'b01, 2'b01, 3, 43, 0, 0, 2'b00, 1'b0);
    chk("no bypass ok", int'(bus.alloc_ok), 0);
    drive(2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 1'b0);
    chk("refill free", int'(bus.free_count), 1);
    chk("refill ok", int'(bus.alloc_ok), 1);
    chk("refill tag3", int'(bus.alloc_tag[0]), 3);
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      reset = $urandom_range(0, 299) == 0;
      areq = 2'($urandom);
      ex = 1'b0;
      used = 0;
      for (int i = 0; i < 2; i++) begin
        v[i] = $urandom_range(0, 2) != 0;
        e[i] = $urandom_range(0, 15) == 0;
        rd[i] = $urandom_range(0, 31);
        pd[i] = $urandom_range(0, 63);
        if (v[i] && !ex) begin
          if (e[i]) ex = 1'b1;
          else if (is_dst(rd[i])) begin
            if (used < inflight.size()) pd[i] = inflight[used++];
            else v[i] = 1'b0;
          end
        end
      end
      bus.alloc_req = areq;
      bus.commit_valid = v;
      bus.commit_exception = e;
      bus.commit_arch_rd[0] = areg_t'(rd[0]);
      bus.commit_arch_rd[1] = areg_t'(rd[1]);
      bus.commit_phys_rd[0] = preg_tag_t'(pd[0]);
      bus.commit_phys_rd[1] = preg_tag_t'(pd[1]);
      bus.flush_en = $urandom_range(0, 19) == 0;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
